// File: rtl/instr_class_queue.sv
// Instruction queue that classifies each word (R/I/J, branch, mem, link) at push time; latency 1.
// Backpressure: in_ready drops when full (no bypass); head held while out_ready is low. Perf counters under INSTR_CLASS_PERF_CNT_EN.
module instr_class_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic              out_rtype,
  output logic              out_itype,
  output logic              out_jtype,
  output logic              out_branch,
  output logic              out_mem,
  output logic              out_link,
  input  logic              flush
`ifdef INSTR_CLASS_PERF_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_r,
  output logic [CNT_W-1:0]  cnt_i,
  output logic [CNT_W-1:0]  cnt_j
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_chk
    $error("instr_class_queue: DEPTH must be a power of two >= 2 and CNT_W >= 1");
  end

  // Class vector layout: {rtype, itype, jtype, branch, mem, link}
  function automatic logic [5:0] classify(input logic [5:0] op);
    logic r, j, br, mem, lnk;
    r   = (op == 6'b000000);
    j   = (op == 6'b000010) || (op == 6'b000011);
    br  = (op == 6'b000100) || (op == 6'b000101);
    mem = (op == 6'b100011) || (op == 6'b101011);
    lnk = (op == 6'b000011);
    return {r, ~(r | j), j, br, mem, lnk};
  endfunction

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_instr_mem [DEPTH];
  logic [5:0]    r_cls_mem   [DEPTH];

  logic          w_push;
  logic          w_pop;
  logic          w_mem_we;
  logic [5:0]    w_in_cls;
  logic [5:0]    w_head_cls;
  logic [31:0]   w_head_instr;

  assign in_ready     = (r_count < C_DEPTH);
  assign out_valid    = (r_count != '0);
  assign w_push       = in_valid && in_ready;
  assign w_pop        = out_valid && out_ready;
  assign w_mem_we     = w_push && !flush && rst_n;
  assign w_in_cls     = classify(in_instr[31:26]);
  assign w_head_cls   = r_cls_mem[r_rptr];
  assign w_head_instr = r_instr_mem[r_rptr];

  // Storage is unreset; stale contents never reach the outputs because of the out_valid gating.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_instr_mem[r_wptr] <= in_instr;
      r_cls_mem[r_wptr]   <= w_in_cls;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_instr  = out_valid ? w_head_instr : 32'h0;
  assign out_rtype  = out_valid & w_head_cls[5];
  assign out_itype  = out_valid & w_head_cls[4];
  assign out_jtype  = out_valid & w_head_cls[3];
  assign out_branch = out_valid & w_head_cls[2];
  assign out_mem    = out_valid & w_head_cls[1];
  assign out_link   = out_valid & w_head_cls[0];

`ifdef INSTR_CLASS_PERF_CNT_EN
  logic [CNT_W-1:0] r_cnt_r;
  logic [CNT_W-1:0] r_cnt_i;
  logic [CNT_W-1:0] r_cnt_j;
  logic             w_retire;

  // A flushed cycle retires nothing even if the consumer was ready.
  assign w_retire = w_pop && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_r <= '0;
      r_cnt_i <= '0;
      r_cnt_j <= '0;
    end else if (cnt_clr) begin
      r_cnt_r <= '0;
      r_cnt_i <= '0;
      r_cnt_j <= '0;
    end else if (w_retire) begin
      if (w_head_cls[5] && (r_cnt_r != '1)) r_cnt_r <= r_cnt_r + CNT_W'(1);
      if (w_head_cls[4] && (r_cnt_i != '1)) r_cnt_i <= r_cnt_i + CNT_W'(1);
      if (w_head_cls[3] && (r_cnt_j != '1)) r_cnt_j <= r_cnt_j + CNT_W'(1);
    end
  end

  assign cnt_r = r_cnt_r;
  assign cnt_i = r_cnt_i;
  assign cnt_j = r_cnt_j;
`endif

endmodule

// File: tb/tb_instr_class_queue.sv
// Bench for instr_class_queue: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_instr_class_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_rtype, out_itype, out_jtype, out_branch, out_mem, out_link;
  logic        flush;
  logic        cnt_clr;
  logic [CNT_W-1:0] cnt_r, cnt_i, cnt_j;
  logic [5:0]  dut_cls;

  int checks = 0;
  int failures = 0;

  logic [31:0] mq[$];
  int          m_cnt[3];

  always #5 clk = ~clk;

  assign dut_cls = {out_rtype, out_itype, out_jtype, out_branch, out_mem, out_link};

  instr_class_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_rtype(out_rtype), .out_itype(out_itype), .out_jtype(out_jtype),
    .out_branch(out_branch), .out_mem(out_mem), .out_link(out_link),
    .flush(flush)
`ifdef INSTR_CLASS_PERF_CNT_EN
    , .cnt_clr(cnt_clr), .cnt_r(cnt_r), .cnt_i(cnt_i), .cnt_j(cnt_j)
`endif
  );

`ifndef INSTR_CLASS_PERF_CNT_EN
  assign cnt_r = '0;
  assign cnt_i = '0;
  assign cnt_j = '0;
`endif

  // Reference classification {r,i,j,branch,mem,link} straight from the opcode table.
  function automatic logic [5:0] ref_cls(input logic [31:0] ins);
    logic [5:0] op;
    logic r, j;
    op = ins[31:26];
    r = (op == 6'd0);
    j = (op == 6'd2) || (op == 6'd3);
    return {r, !r && !j, j, (op == 6'd4) || (op == 6'd5), (op == 6'd35) || (op == 6'd43), op == 6'd3};
  endfunction

  function automatic logic [31:0] exp_instr();
    return (mq.size() != 0) ? mq[0] : 32'h0;
  endfunction

  function automatic logic [5:0] exp_cls();
    return (mq.size() != 0) ? ref_cls(mq[0]) : 6'h0;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
  endtask

  // Drive one cycle and advance the model; returns #1 after the edge.
  task automatic step(input logic iv, input logic [31:0] ins, input logic ordy,
                      input logic fl, input logic clr);
    bit p_push, p_pop;
    logic [5:0] c;
    in_valid = iv; in_instr = ins; out_ready = ordy; flush = fl; cnt_clr = clr;
    p_push = iv && (mq.size() < DEPTH);
    p_pop  = ordy && (mq.size() != 0);
    c = p_pop ? ref_cls(mq[0]) : 6'h0;
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (p_pop) void'(mq.pop_front());
      if (p_push) mq.push_back(ins);
    end
    if (clr) begin
      for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    end else if (p_pop && !fl) begin
      int idx;
      idx = c[5] ? 0 : (c[4] ? 1 : 2);
      if (m_cnt[idx] < CMAX) m_cnt[idx]++;
    end
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DEPTH && mq.size() != 0; k++) step(0, 32'h0, 1, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; in_instr = 0; out_ready = 0; flush = 0; cnt_clr = 0;
    model_reset();
    #12;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_hs out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    checks++;
    if (out_instr !== 32'h0 || dut_cls !== 6'h0) begin
      failures++; $display("FAIL reset_out instr=%h cls=%b want 0", out_instr, dut_cls);
    end
`ifdef INSTR_CLASS_PERF_CNT_EN
    checks++;
    if (cnt_r !== 0 || cnt_i !== 0 || cnt_j !== 0) begin
      failures++; $display("FAIL reset_cnt r=%0d i=%0d j=%0d want 0", cnt_r, cnt_i, cnt_j);
    end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    step(1, 32'h012A4020, 1, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h012A4020 || dut_cls !== 6'b100000) begin
      failures++; $display("FAIL add_head vld=%b instr=%h cls=%b want 1/012a4020/100000", out_valid, out_instr, dut_cls);
    end
    step(0, 32'h0, 1, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0) begin
      failures++; $display("FAIL add_pop vld=%b instr=%h want 0/0", out_valid, out_instr);
    end
`ifdef INSTR_CLASS_PERF_CNT_EN
    checks++;
    if (cnt_r !== 2'd1) begin
      failures++; $display("FAIL add_cnt cnt_r=%0d want 1", cnt_r);
    end
`endif
  endtask

  task automatic test_fill_order();
    logic [31:0] ins [4];
    logic [5:0]  cls [4];
    ins[0] = 32'h0C000010; ins[1] = 32'h08000004; ins[2] = 32'h8C220000; ins[3] = 32'h10000003;
    cls[0] = 6'b001001;    cls[1] = 6'b001000;    cls[2] = 6'b010010;    cls[3] = 6'b010100;
    for (int k = 0; k < 4; k++) step(1, ins[k], 0, 0, 0);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL fill_full in_ready=%b want 0", in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_instr !== ins[k] || dut_cls !== cls[k]) begin
        failures++; $display("FAIL fill_head%0d vld=%b instr=%h cls=%b want 1/%h/%b", k, out_valid, out_instr, dut_cls, ins[k], cls[k]);
      end
      step(0, 32'h0, 1, 0, 0);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL fill_empty out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] ins [6];
    for (int k = 0; k < 6; k++) ins[k] = $urandom();
    for (int k = 0; k < 4; k++) step(1, ins[k], 0, 0, 0);
    step(1, ins[4], 1, 0, 0);
    checks++;
    if (in_ready !== 1'b1 || out_instr !== ins[1]) begin
      failures++; $display("FAIL fullpp_pop in_ready=%b head=%h want 1/%h", in_ready, out_instr, ins[1]);
    end
    step(1, ins[5], 0, 0, 0);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL fullpp_push in_ready=%b want 0", in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      logic [31:0] want;
      want = (k < 3) ? ins[k + 1] : ins[5];
      checks++;
      if (out_instr !== want || dut_cls !== ref_cls(want)) begin
        failures++; $display("FAIL fullpp_order%0d instr=%h cls=%b want %h/%b", k, out_instr, dut_cls, want, ref_cls(want));
      end
      step(0, 32'h0, 1, 0, 0);
    end
  endtask

  task automatic test_flush();
    int saved[3];
    step(1, 32'h00851020, 0, 0, 0);
    step(1, 32'h8C010004, 0, 0, 0);
    saved = m_cnt;
    step(1, 32'h0C000001, 1, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0) begin
      failures++; $display("FAIL flush_empty vld=%b rdy=%b instr=%h want 0/1/0", out_valid, in_ready, out_instr);
    end
`ifdef INSTR_CLASS_PERF_CNT_EN
    checks++;
    if (cnt_r !== saved[0][CNT_W-1:0] || cnt_i !== saved[1][CNT_W-1:0] || cnt_j !== saved[2][CNT_W-1:0]) begin
      failures++; $display("FAIL flush_cnt r=%0d i=%0d j=%0d want %0d/%0d/%0d", cnt_r, cnt_i, cnt_j, saved[0], saved[1], saved[2]);
    end
`endif
    step(1, 32'h10220003, 0, 0, 0);
    checks++;
    if (out_instr !== 32'h10220003 || dut_cls !== 6'b010100) begin
      failures++; $display("FAIL flush_restart instr=%h cls=%b want 10220003/010100", out_instr, dut_cls);
    end
    drain();
  endtask

  task automatic test_cnt_sat();
`ifdef INSTR_CLASS_PERF_CNT_EN
    step(0, 32'h0, 0, 0, 1);
    checks++;
    if (cnt_r !== 2'd0) begin
      failures++; $display("FAIL sat_clr cnt_r=%0d want 0", cnt_r);
    end
    for (int k = 0; k < 5; k++) begin
      step(1, 32'h00000020 | k, 0, 0, 0);
      step(0, 32'h0, 1, 0, 0);
    end
    checks++;
    if (cnt_r !== 2'd3) begin
      failures++; $display("FAIL sat_hold cnt_r=%0d want 3", cnt_r);
    end
    step(1, 32'h00000022, 0, 0, 0);
    step(0, 32'h0, 1, 0, 1);
    checks++;
    if (cnt_r !== 2'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL sat_clrpop cnt_r=%0d vld=%b want 0/0", cnt_r, out_valid);
    end
`endif
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) step(1, 32'h20000000 + k, 0, 0, 0);
    in_valid = 1; in_instr = 32'h0000002A; out_ready = 1;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0) begin
      failures++; $display("FAIL async_rst vld=%b rdy=%b instr=%h want 0/1/0", out_valid, in_ready, out_instr);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL async_hold vld=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    in_valid = 0; out_ready = 0;
    rst_n = 1'b1;
    model_reset();
    step(1, 32'h0800000F, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0800000F || dut_cls !== 6'b001000) begin
      failures++; $display("FAIL async_resume vld=%b instr=%h cls=%b want 1/0800000f/001000", out_valid, out_instr, dut_cls);
    end
    drain();
  endtask

  task automatic test_random();
    logic [5:0] ops [10];
    ops[0] = 6'd0; ops[1] = 6'd2; ops[2] = 6'd3; ops[3] = 6'd4; ops[4] = 6'd5;
    ops[5] = 6'd35; ops[6] = 6'd43; ops[7] = 6'd8; ops[8] = 6'd1; ops[9] = 6'd63;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] rnd;
      logic [5:0]  op;
      int sel;
      rnd = $urandom();
      sel = $urandom_range(0, 10);
      op  = (sel < 10) ? ops[sel] : rnd[31:26];
      step($urandom_range(0, 3) != 0, {op, rnd[25:0]}, $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 40) == 0);
      checks++;
      if (out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < DEPTH)) begin
        failures++; $display("FAIL rand_hs%0d vld=%b rdy=%b want %b/%b", n, out_valid, in_ready, mq.size() != 0, mq.size() < DEPTH);
      end
      checks++;
      if (out_instr !== exp_instr() || dut_cls !== exp_cls()) begin
        failures++; $display("FAIL rand_head%0d instr=%h cls=%b want %h/%b", n, out_instr, dut_cls, exp_instr(), exp_cls());
      end
`ifdef INSTR_CLASS_PERF_CNT_EN
      checks++;
      if (cnt_r !== m_cnt[0][CNT_W-1:0] || cnt_i !== m_cnt[1][CNT_W-1:0] || cnt_j !== m_cnt[2][CNT_W-1:0]) begin
        failures++; $display("FAIL rand_cnt%0d r=%0d i=%0d j=%0d want %0d/%0d/%0d", n, cnt_r, cnt_i, cnt_j, m_cnt[0], m_cnt[1], m_cnt[2]);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_fill_order();
    test_full_push_pop();
    test_flush();
    test_cnt_sat();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_class_queue.md
INSTR_CLASS_QUEUE -- requirements
Module: instr_class_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-002 SHALL have parameter CNT_W, default 16, width of each class counter.
REQ-003 SHALL have ports clk in 1, single rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-004 SHALL have ports in_valid in 1, instruction offered; in_ready out 1, queue can accept; in_instr in 32, instruction word.
REQ-005 SHALL have ports out_valid out 1, head entry present; out_ready in 1, consumer takes head.
REQ-006 SHALL have ports out_instr out 32, head instruction; out_rtype, out_itype, out_jtype out 1 each, head class.
REQ-007 SHALL have ports out_branch out 1, opcode 000100/000101; out_mem out 1, opcode 100011/101011; out_link out 1, opcode 000011.
REQ-008 SHALL have port flush in 1, discards all queued entries.
REQ-009 SHALL have ports cnt_clr in 1, clears counters; cnt_r, cnt_i, cnt_j out CNT_W each, retired-per-class counts (present only per REQ-026).

Function
REQ-010 SHALL classify on opcode = in_instr[31:26]: 000000 -> rtype; 000010 or 000011 -> jtype; all other values -> itype; exactly one class bit is set per entry.
REQ-011 SHALL compute class, branch, mem and link bits at push time and store them with the instruction in the entry.
REQ-012 SHALL push when in_valid && in_ready; pop when out_valid && out_ready.
REQ-013 SHALL drive in_ready = (count < DEPTH), combinationally from registered count only; no bypass, so a push into a full queue is refused even when a pop occurs in the same cycle.
REQ-014 SHALL drive out_valid = (count != 0).
REQ-015 SHALL have latency 1: an instruction pushed at edge N is visible on out_* after edge N when the queue was empty.
REQ-016 SHALL drive out_instr and all class/attribute outputs to 0 whenever out_valid = 0.
REQ-017 SHALL hold the head entry stable while out_valid && !out_ready.
REQ-018 SHALL on simultaneous push and pop with 0 < count < DEPTH perform both, leaving count unchanged and preserving order.
REQ-019 SHALL wrap read and write pointers modulo DEPTH; count ranges 0..DEPTH.
REQ-020 SHALL on flush = 1 set count and both pointers to 0 at the next edge; flush beats push and pop in the same cycle, and no counter increments that cycle.
REQ-021 SHALL ignore in_valid and out_ready while rst_n = 0.

Reset
REQ-022 SHALL on rst_n low immediately, regardless of clk, set count = 0, read and write pointers = 0 and all counters = 0.
REQ-023 SHALL present out_valid = 0, all out_* = 0 and in_ready = 1 during and after reset.
REQ-024 SHALL restore normal operation on the first rising edge after rst_n deasserts; entries pushed before reset are lost.
REQ-025 SHALL not need entry storage to be reset, because REQ-016 gates it.

Configuration
REQ-026 SHALL include cnt_clr, cnt_r, cnt_i and cnt_j plus their logic only when macro INSTR_CLASS_PERF_CNT_EN is defined; without it, those ports are absent and queue behaviour is unchanged.
REQ-027 SHALL with INSTR_CLASS_PERF_CNT_EN increment the counter matching the head class by 1 on each pop.
REQ-028 SHALL saturate each counter at 2^CNT_W-1.
REQ-029 SHALL treat cnt_clr as a synchronous clear that beats an increment in the same cycle, giving 0.

Verification
REQ-030 SHALL cover: reset, then push 0x012A4020 (add) with out_ready = 1 -> next cycle out_valid = 1, out_rtype = 1, others 0; following cycle out_valid = 0, cnt_r = 1.
REQ-031 SHALL cover: out_ready = 0, push 0x0C000010, 0x08000004, 0x8C220000, 0x10000003 -> in_ready = 0 after 4th push; heads in order give jtype+link, jtype, itype+mem, itype+branch.
REQ-032 SHALL cover: full queue, in_valid = 1, out_ready = 1 same cycle -> one pop, no push, count = 3, then push accepted next cycle.
REQ-033 SHALL cover: count = 2, flush = 1 with in_valid = out_ready = 1 -> next cycle count = 0, out_valid = 0, counters unchanged.
REQ-034 SHALL cover: CNT_W = 2, five rtype pops -> cnt_r stays 3; cnt_clr with a concurrent pop -> cnt_r = 0.
REQ-035 SHALL cover: rst_n asserted mid-cycle with count = 3 -> out_valid = 0 and in_ready = 1 before the next clk edge.
